// File: rtl/rng_seed_loader.sv
// Seed loader: takes a valid/ready byte stream and writes it, byte 0 first, into the RNG
// state array through one-hot byte enables. Reports done, XOR checksum and all-zero flag.
module rng_seed_loader #(
  parameter int unsigned NUM_BYTES  = 32,
  parameter int unsigned TOTAL_BITS = 8 * NUM_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [NUM_BYTES-1:0]  w_en_bytes,
  output logic [TOTAL_BITS-1:0] w_data_bytes,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            seed_xor,
  output logic                  seed_zero
);

  localparam int unsigned IdxW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [7:0]            xor_acc_q, xor_acc_d;
  logic                  zero_acc_q, zero_acc_d;
  logic [NUM_BYTES-1:0]  w_en_q, w_en_d;
  logic [TOTAL_BITS-1:0] w_data_q, w_data_d;
  logic                  done_q, done_d;
  logic [7:0]            seed_xor_q, seed_xor_d;
  logic                  seed_zero_q, seed_zero_d;
  logic                  hs;

  // abort masks ready so a byte offered in the abort cycle is never taken
  assign s_ready = (state_q == StLoad) && !abort;
  assign hs      = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    xor_acc_d   = xor_acc_q;
    zero_acc_d  = zero_acc_q;
    w_en_d      = '0;
    w_data_d    = '0;
    done_d      = 1'b0;
    seed_xor_d  = seed_xor_q;
    seed_zero_d = seed_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          idx_d      = '0;
          xor_acc_d  = '0;
          zero_acc_d = 1'b1;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else if (hs) begin
          w_en_d[idx_q]             = 1'b1;
          w_data_d[8*idx_q +: 8]    = s_data;
          xor_acc_d                 = xor_acc_q ^ s_data;
          zero_acc_d                = zero_acc_q && (s_data == 8'h00);
          if (idx_q == LastIdx) begin
            state_d = StFlush;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StFlush: begin
        // last write is on the bus this cycle; publish status with done next cycle
        state_d     = StIdle;
        done_d      = 1'b1;
        seed_xor_d  = xor_acc_q;
        seed_zero_d = zero_acc_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      xor_acc_q   <= '0;
      zero_acc_q  <= 1'b0;
      w_en_q      <= '0;
      w_data_q    <= '0;
      done_q      <= 1'b0;
      seed_xor_q  <= '0;
      seed_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      xor_acc_q   <= xor_acc_d;
      zero_acc_q  <= zero_acc_d;
      w_en_q      <= w_en_d;
      w_data_q    <= w_data_d;
      done_q      <= done_d;
      seed_xor_q  <= seed_xor_d;
      seed_zero_q <= seed_zero_d;
    end
  end

  assign w_en_bytes   = w_en_q;
  assign w_data_bytes = w_data_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign seed_xor     = seed_xor_q;
  assign seed_zero    = seed_zero_q;

  a_wen_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(w_en_bytes));
  a_done_idle:  assert property (@(posedge clk) disable iff (rst) done |-> !busy);

endmodule

// File: tb/tb_rng_seed_loader.sv
// Randomised bench for rng_seed_loader: a per-cycle load model predicts writes and
// completions into queues; a negedge monitor pops and compares them against the DUT.
module tb_rng_seed_loader;

  localparam int NB = 32;
  localparam int TB = 8 * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready, busy, done, seed_zero;
  logic [NB-1:0] w_en_bytes;
  logic [TB-1:0] w_data_bytes;
  logic [7:0]    seed_xor;

  rng_seed_loader #(.NUM_BYTES(NB), .TOTAL_BITS(TB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .w_en_bytes(w_en_bytes),
    .w_data_bytes(w_data_bytes), .busy(busy), .done(done), .seed_xor(seed_xor),
    .seed_zero(seed_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: load phase, bytes taken so far, running checksum
  typedef enum {MIdle, MLoad, MFlush} phase_e;
  typedef struct {int cyc; int idx; logic [7:0] d;} wr_t;
  typedef struct {int cyc; logic [7:0] x; logic z;} dn_t;

  phase_e     phase = MIdle;
  int         m_count;
  logic [7:0] m_xor;
  logic       m_zero;
  logic [7:0] held_xor = '0;
  logic       held_zero = 1'b0;
  wr_t        wq[$];
  dn_t        dq[$];

  task automatic step(input bit st, input bit ab, input bit v, input logic [7:0] d);
    @(posedge clk);
    #1;
    start = st; abort = ab; s_valid = v; s_data = d;
    #1;
    chk("s_ready", s_ready, (phase == MLoad) && !ab);
    chk("busy", busy, phase != MIdle);
    case (phase)
      MIdle: if (st) begin
        phase = MLoad; m_count = 0; m_xor = 8'h00; m_zero = 1'b1;
      end
      MLoad: begin
        if (ab) phase = MIdle;
        else if (v) begin
          wq.push_back('{cyc: cyc + 1, idx: m_count, d: d});
          m_xor  = m_xor ^ d;
          m_zero = m_zero && (d == 8'h00);
          m_count++;
          if (m_count == NB) begin
            dq.push_back('{cyc: cyc + 2, x: m_xor, z: m_zero});
            phase = MFlush;
          end
        end
      end
      default: phase = MIdle;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b1; s_data = 8'h5A;
    wq.delete(); dq.delete();
    phase = MIdle; held_xor = '0; held_zero = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_w_en", w_en_bytes, 0);
    chk("rst_w_data", w_data_bytes, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seed_xor", seed_xor, 0);
    chk("rst_seed_zero", seed_zero, 0);
    @(posedge clk);
    #3;
    rst = 1'b0; s_valid = 1'b0;
  endtask

  logic [NB-1:0] exp_en;
  logic [TB-1:0] exp_data;

  always @(negedge clk) begin
    if (!rst) begin
      if (w_en_bytes != '0) begin
        if (wq.size() == 0) chk("spurious_wen", w_en_bytes, 0);
        else begin
          wr_t e;
          e = wq.pop_front();
          exp_en = '0; exp_en[e.idx] = 1'b1;
          exp_data = '0; exp_data[8*e.idx +: 8] = e.d;
          chk("wen_cycle", cyc, e.cyc);
          chk("w_en_bytes", w_en_bytes, exp_en);
          chk("w_data_bytes", w_data_bytes, exp_data);
        end
      end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
        chk("missed_wen", w_en_bytes, 1 << wq[0].idx);
        void'(wq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) chk("spurious_done", done, 0);
        else begin
          dn_t e;
          e = dq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          held_xor = e.x; held_zero = e.z;
        end
      end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
        chk("missed_done", done, 1);
        held_xor = dq[0].x; held_zero = dq[0].z;
        void'(dq.pop_front());
      end
      chk("seed_xor", seed_xor, held_xor);
      chk("seed_zero", seed_zero, held_zero);
    end
  end

  initial begin
    // 1: reset, idle with traffic and stray abort
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    // 2: bytes 0x01..0x20 back-to-back; start with s_valid is not a handshake
    step(1'b1, 1'b0, 1'b1, 8'hEE);
    for (int i = 0; i < NB; i++) step(1'b0, 1'b0, 1'b1, 8'(i + 1));
    idle(3);
    // 3: s_valid toggling
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2 * NB; i++) step(1'b0, 1'b0, (i % 2) == 0, 8'($urandom));
    idle(3);
    // 4: all-zero seed
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < NB; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    idle(3);
    // 5: abort after 5 bytes with s_valid high, then 0xFF reload
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
    step(1'b0, 1'b1, 1'b1, 8'h99);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < NB; i++) step(1'b0, 1'b0, 1'b1, 8'hFF);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    idle(3);
    // 6: start while busy, then reset at byte 10
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom));
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'h11);
    idle(2);
    // randomised loads with gaps, stray starts and occasional aborts
    for (int n = 0; n < 10; n++) begin
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      for (int g = 0; g < 400 && phase != MIdle; g++)
        step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 9) < 7, 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      idle(3);
    end
    idle(3);
    chk("wq_drained", wq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
